mem_req_arbiter: RTL

// - Shares one SRAM-like memory port (CPU side of the AXI bridge) between the inst and data requesters.
// - Sits between the CPU core and cpu_axi_interface. Serialises requests with one transaction in flight.
// - Routes addr_ok/data_ok back to the owning requester. Data has priority by default.

---
 rtl/mem_req_arbiter_if.sv | 29 ++
 rtl/mem_req_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter_if.sv
// One SRAM-like memory request port, as seen on the CPU side of the AXI bridge.
// Ports: req/wr/size/addr/wdata travel from the requester (master) to the acceptor (slave);
//        rdata/addr_ok/data_ok travel back from the acceptor to the requester.
// A requester holds req and its fields stable until addr_ok; data_ok closes the transaction.
interface mem_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              addr_ok;
  logic              data_ok;

  // Requester side: issues the request, receives the handshakes and read data.
  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  // Acceptor side: receives the request, returns the handshakes and read data.
  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like memory port between the inst and data requesters, one transaction in flight.
// Latency: 1 cycle of arbitration in IDLE before mem_req; responses are routed combinationally.
// Backpressure: a losing or late requester simply keeps req high; it never sees addr_ok/data_ok.
// Ports: clk, reset (async, active-high); inst, data = requester ports (slave modport);
//        mem = port towards the AXI bridge (master modport).
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants on a tie (default: data wins).
module mem_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_req_arbiter_if.slave  inst,
  mem_req_arbiter_if.slave  data,
  mem_req_arbiter_if.master mem
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  state_t state;
  state_t state_nxt;
  owner_t owner;
  owner_t owner_nxt;
  owner_t winner;

  // Owner's live request fields
  logic              owner_req;
  logic              owner_wr;
  logic [1:0]        owner_size;
  logic [ADDR_W-1:0] owner_addr;
  logic [DATA_W-1:0] owner_wdata;

  // FSM outputs
  logic              mem_req_d;
  logic              mem_wr_d;
  logic [1:0]        mem_size_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              inst_addr_ok_d;
  logic              data_addr_ok_d;
  logic              inst_data_ok_d;
  logic              data_data_ok_d;

`ifdef ARB_ROUND_ROBIN_EN
  // Requester that most recently entered ADDR; the other one wins the next tie.
  owner_t rr_last;
`endif

  // Arbitration: a lone requester always wins; only a tie needs a policy.
  always_comb begin
    winner = OWN_NONE;
    if (inst.req && data.req) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = (rr_last == OWN_INST) ? OWN_DATA : OWN_INST;
`else
      winner = OWN_DATA;
`endif
    end else if (data.req) begin
      winner = OWN_DATA;
    end else if (inst.req) begin
      winner = OWN_INST;
    end
  end

  // Mux of the owner's inputs. Fields are taken live, not latched, because the
  // requester holds them stable until it sees addr_ok.
  always_comb begin
    owner_req   = 1'b0;
    owner_wr    = 1'b0;
    owner_size  = 2'd0;
    owner_addr  = '0;
    owner_wdata = '0;
    case (owner)
      OWN_INST: begin
        owner_req   = inst.req;
        owner_wr    = inst.wr;
        owner_size  = inst.size;
        owner_addr  = inst.addr;
        owner_wdata = inst.wdata;
      end
      OWN_DATA: begin
        owner_req   = data.req;
        owner_wr    = data.wr;
        owner_size  = data.size;
        owner_addr  = data.addr;
        owner_wdata = data.wdata;
      end
      default: ;
    endcase
  end

  // State and owner registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      owner <= OWN_NONE;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last <= OWN_INST;
    end else if (state == ST_IDLE && state_nxt == ST_ADDR) begin
      rr_last <= owner_nxt;
    end
  end
`endif

  // Next state and outputs
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    mem_req_d      = 1'b0;
    mem_wr_d       = 1'b0;
    mem_size_d     = 2'd0;
    mem_addr_d     = '0;
    mem_wdata_d    = '0;
    inst_addr_ok_d = 1'b0;
    data_addr_ok_d = 1'b0;
    inst_data_ok_d = 1'b0;
    data_data_ok_d = 1'b0;

    case (state)
      ST_IDLE: begin
        // mem_req stays low here; any mem_data_ok seen now has no owner and is dropped.
        if (winner != OWN_NONE) begin
          owner_nxt = winner;
          state_nxt = ST_ADDR;
        end
      end

      ST_ADDR: begin
        mem_req_d      = 1'b1;
        mem_wr_d       = owner_wr;
        mem_size_d     = owner_size;
        mem_addr_d     = owner_addr;
        mem_wdata_d    = owner_wdata;
        inst_addr_ok_d = (owner == OWN_INST) && mem.addr_ok;
        data_addr_ok_d = (owner == OWN_DATA) && mem.addr_ok;
        // Acceptance takes precedence over a withdrawn req: once the bridge has
        // taken the request its response must still be collected in WAIT.
        if (mem.addr_ok) begin
          state_nxt = ST_WAIT;
        end else if (!owner_req) begin
          state_nxt = ST_IDLE;
          owner_nxt = OWN_NONE;
        end
      end

      ST_WAIT: begin
        inst_data_ok_d = (owner == OWN_INST) && mem.data_ok;
        data_data_ok_d = (owner == OWN_DATA) && mem.data_ok;
        // No bypass: a req arriving with data_ok is arbitrated in IDLE next cycle.
        if (mem.data_ok) begin
          state_nxt = ST_IDLE;
          owner_nxt = OWN_NONE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  assign mem.req      = mem_req_d;
  assign mem.wr       = mem_wr_d;
  assign mem.size     = mem_size_d;
  assign mem.addr     = mem_addr_d;
  assign mem.wdata    = mem_wdata_d;

  assign inst.addr_ok = inst_addr_ok_d;
  assign inst.data_ok = inst_data_ok_d;
  assign data.addr_ok = data_addr_ok_d;
  assign data.data_ok = data_data_ok_d;

  // Read data is shared; only the data_ok strobe identifies the real recipient.
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  // An owner exists exactly while a transaction is being issued or awaited.
  a_owner_state: assert property (@(posedge clk) disable iff (reset)
    (state == ST_IDLE) == (owner == OWN_NONE));

  // Handshakes are only ever routed to a single requester.
  a_one_addr_ok: assert property (@(posedge clk) disable iff (reset)
    !(inst.addr_ok && data.addr_ok));
  a_one_data_ok: assert property (@(posedge clk) disable iff (reset)
    !(inst.data_ok && data.data_ok));

endmodule
